// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the pipeline control unit: control-word bit
// positions, opcode constants, instruction field slices, the bubble word,
// the per-stage record and an opcode classifier used by the decoder.
package pipe_ctrl_pkg;

    // Control-word bit positions
    localparam int B_ESC_COND_CP = 0;
    localparam int B_ESC_CP      = 1;
    localparam int B_ULA_A0      = 2;
    localparam int B_ULA_B_LO    = 3;
    localparam int B_ULA_B_HI    = 4;
    localparam int B_ESC_IR      = 5;
    localparam int B_FONTE_CP_LO = 6;
    localparam int B_FONTE_CP_HI = 7;
    localparam int B_ESC_REG     = 8;
    localparam int B_ULA_A1      = 9;
    localparam int B_MUL         = 10;
    localparam int B_OP_LO       = 11;
    localparam int B_OP_HI       = 14;

    // Multi-bit field encodings
    localparam logic [1:0] ULA_B_IMM = 2'b10;
    localparam logic [1:0] ULA_B_FWD = 2'b11;
    localparam logic [1:0] FONTE_BR  = 2'b01;
    localparam logic [1:0] FONTE_JMP = 2'b10;

    // Opcodes with dedicated decode
    localparam logic [3:0] OP_JMP = 4'd11;
    localparam logic [3:0] OP_BR  = 4'd12;
    localparam logic [3:0] OP_MUL = 4'd15;

    // Instruction field slices (also valid on the 12-bit register record)
    localparam int OP_HI = 15;
    localparam int OP_LO = 12;
    localparam int RD_HI = 11;
    localparam int RD_LO = 8;
    localparam int RS_HI = 7;
    localparam int RS_LO = 4;
    localparam int RT_HI = 3;
    localparam int RT_LO = 0;

    localparam logic [15:0] BUBBLE = 16'h0002;

    // One pipeline stage: liveness, control word, register fields
    typedef struct packed {
        logic        valid;
        logic [15:0] ctrl;
        logic [11:0] regs;
    } stage_t;

    localparam stage_t BUBBLE_STAGE = '{valid: 1'b0, ctrl: BUBBLE, regs: 12'h000};

    typedef enum logic [2:0] {
        OPC_ALU,
        OPC_IMM,
        OPC_JMP,
        OPC_BR,
        OPC_MUL
    } op_class_e;

    function automatic op_class_e classify(input logic [3:0] op);
        op_class_e cls;
        case (op)
            4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10: cls = OPC_IMM;
            OP_JMP:                              cls = OPC_JMP;
            OP_BR:                               cls = OPC_BR;
            OP_MUL:                              cls = OPC_MUL;
            default:                             cls = OPC_ALU;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/pipe_ctrl_decode.sv
// ctrl_decode
// Combinational opcode decoder: maps one 16-bit instruction to its raw
// 16-bit control word. Forwarding adjustments are applied by the caller.
// Ports:
//   inst  in  16  instruction (op[15:12], rd[11:8], rs[7:4], rt[3:0])
//   ctrl  out 16  decoded control word
module ctrl_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [15:0] inst,
    output logic [15:0] ctrl
);

    always_comb begin
        // NOTE: default every bit first so no path through the case leaves
        // ctrl unassigned, which would otherwise infer a latch.
        ctrl = '0;
        ctrl[B_OP_HI:B_OP_LO] = inst[OP_HI:OP_LO];
        case (classify(inst[OP_HI:OP_LO]))
            OPC_ALU: begin
                ctrl[B_ESC_CP]  = 1'b1;
                ctrl[B_ULA_A0]  = 1'b1;
                ctrl[B_ESC_REG] = 1'b1;
            end
            OPC_IMM: begin
                ctrl[B_ESC_CP]                = 1'b1;
                ctrl[B_ULA_A0]                = 1'b1;
                ctrl[B_ESC_REG]               = 1'b1;
                ctrl[B_ULA_B_HI:B_ULA_B_LO]   = ULA_B_IMM;
            end
            OPC_JMP: begin
                ctrl[B_ESC_CP]                  = 1'b1;
                ctrl[B_ULA_A0]                  = 1'b1;
                ctrl[B_ULA_B_HI:B_ULA_B_LO]     = ULA_B_IMM;
                ctrl[B_FONTE_CP_HI:B_FONTE_CP_LO] = FONTE_JMP;
            end
            OPC_BR: begin
                ctrl[B_ESC_COND_CP]               = 1'b1;
                ctrl[B_ESC_CP]                    = 1'b1;
                ctrl[B_FONTE_CP_HI:B_FONTE_CP_LO] = FONTE_BR;
            end
            OPC_MUL: begin
                // PC write stays off: the multiply holds issue until done
                ctrl[B_ULA_A0]  = 1'b1;
                ctrl[B_ESC_REG] = 1'b1;
                ctrl[B_MUL]     = 1'b1;
            end
            default: ;
        endcase
        // IR write enable belongs to the fetch side, never to decode
        ctrl[B_ESC_IR] = 1'b0;
        // The all-zero instruction is the canonical no-op
        if (inst == 16'h0000) begin
            ctrl = BUBBLE;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
// Pipeline control unit: decodes each issued instruction, carries control
// words and register fields through DEPTH stages with a valid bit each,
// resolves operand forwarding from the nearest older producer, stalls issue
// while a multi-cycle multiply is in flight and bubbles the two youngest
// stages on a taken branch/jump.
// Ports:
//   clk          in   1         clock, all state on rising edge
//   rst_n        in   1         synchronous active-low reset
//   inst_valid   in   1         instruction presented for issue
//   inst         in   16        instruction word
//   flush        in   1         taken branch/jump: kill younger work
//   stall        out  1         issue refused this cycle (hold PC/IR)
//   ctrl_stage   out  16*DEPTH  control word per stage, slice k = stage k
//   regs_stage   out  12*DEPTH  inst[11:0] per stage
//   valid_stage  out  DEPTH     stage holds a live instruction
//   fwd_sel_a/b  out  SEL_W     forward source for rs/rt of stage 0
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DEPTH   = 3,
    parameter int MUL_LAT = 2,
    parameter int SEL_W   = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inst_valid,
    input  logic [15:0]           inst,
    input  logic                  flush,
    output logic                  stall,
    output logic [16*DEPTH-1:0]   ctrl_stage,
    output logic [12*DEPTH-1:0]   regs_stage,
    output logic [DEPTH-1:0]      valid_stage,
    output logic [SEL_W-1:0]      fwd_sel_a,
    output logic [SEL_W-1:0]      fwd_sel_b
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    stage_t           stage_q [DEPTH];
    logic [CNT_W-1:0] mul_cnt;
    logic [15:0]      dec_ctrl;
    logic [15:0]      issue_word;
    logic [DEPTH-2:0] hit_a;
    logic [DEPTH-2:0] hit_b;
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic             issue;

    ctrl_decode u_decode (
        .inst (inst),
        .ctrl (dec_ctrl)
    );

    assign stall = (mul_cnt != '0);
    assign issue = inst_valid && !stall && !flush;

    // Producer compare against every stage that can still feed stage 0
    for (genvar k = 0; k < DEPTH - 1; k++) begin : g_fwd
        logic producer;
        assign producer = stage_q[k].valid && stage_q[k].ctrl[B_ESC_REG];
        assign hit_a[k] = producer && (stage_q[k].regs[RD_HI:RD_LO] == inst[RS_HI:RS_LO]);
        assign hit_b[k] = producer && (stage_q[k].regs[RD_HI:RD_LO] == inst[RT_HI:RT_LO]);
    end

    // Scan oldest to youngest so the nearest producer overwrites the rest
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            if (hit_a[k]) sel_a = SEL_W'(k + 1);
            if (hit_b[k]) sel_b = SEL_W'(k + 1);
        end
    end

    always_comb begin
        issue_word = dec_ctrl;
        if (sel_a != '0) begin
            issue_word[B_ULA_A1] = 1'b1;
            issue_word[B_ULA_A0] = 1'b0;
        end
        if (sel_b != '0) begin
            issue_word[B_ULA_B_HI:B_ULA_B_LO] = ULA_B_FWD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the stage array is reset element by element because the
            // outputs must read all-zero after reset, not just invalid.
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
            mul_cnt   <= '0;
            fwd_sel_a <= '0;
            fwd_sel_b <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage read its
            // neighbour's old value; the later flush write to stage 1 simply
            // overrides the shift scheduled above it.
            for (int k = DEPTH - 1; k >= 1; k--) begin
                stage_q[k] <= stage_q[k-1];
            end
            if (flush) begin
                stage_q[1] <= BUBBLE_STAGE;
            end

            if (issue) begin
                stage_q[0] <= '{valid: 1'b1, ctrl: issue_word, regs: inst[11:0]};
                fwd_sel_a  <= sel_a;
                fwd_sel_b  <= sel_b;
            end else begin
                stage_q[0] <= BUBBLE_STAGE;
                fwd_sel_a  <= '0;
                fwd_sel_b  <= '0;
            end

            // Flush aborts an in-flight multiply; issue of a multiply cannot
            // coincide with a nonzero count because stall blocks it.
            if (flush) begin
                mul_cnt <= '0;
            end else if (issue && dec_ctrl[B_MUL]) begin
                mul_cnt <= CNT_W'(MUL_LAT - 1);
            end else if (mul_cnt != '0) begin
                mul_cnt <= mul_cnt - CNT_W'(1);
            end
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_out
        assign ctrl_stage[16*k +: 16] = stage_q[k].ctrl;
        assign regs_stage[12*k +: 12] = stage_q[k].regs;
        assign valid_stage[k]         = stage_q[k].valid;
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl
// Directed scenarios with hand-derived control words, then randomized
// traffic checked against a cycle-level behavioural model of the pipeline.
module tb_pipe_ctrl;

    localparam int DEPTH   = 3;
    localparam int MUL_LAT = 3;
    localparam int SEL_W   = $clog2(DEPTH) + 1;

    logic                clk;
    logic                rst_n;
    logic                inst_valid;
    logic [15:0]         inst;
    logic                flush;
    logic                stall;
    logic [16*DEPTH-1:0] ctrl_stage;
    logic [12*DEPTH-1:0] regs_stage;
    logic [DEPTH-1:0]    valid_stage;
    logic [SEL_W-1:0]    fwd_sel_a;
    logic [SEL_W-1:0]    fwd_sel_b;

    int total = 0;
    int bad   = 0;

    pipe_ctrl #(.DEPTH(DEPTH), .MUL_LAT(MUL_LAT), .SEL_W(SEL_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .flush       (flush),
        .stall       (stall),
        .ctrl_stage  (ctrl_stage),
        .regs_stage  (regs_stage),
        .valid_stage (valid_stage),
        .fwd_sel_a   (fwd_sel_a),
        .fwd_sel_b   (fwd_sel_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [15:0]      m_ctrl  [DEPTH];
    logic [11:0]      m_regs  [DEPTH];
    logic             m_valid [DEPTH];
    logic [SEL_W-1:0] m_fa;
    logic [SEL_W-1:0] m_fb;
    int               m_left;   // cycles of stall still owed to a multiply

    function automatic logic [15:0] ref_decode(input logic [15:0] in);
        logic [15:0] base;
        logic [15:0] w;
        base = {1'b0, in[15:12], 11'b0};
        case (in[15:12])
            4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd13, 4'd14: w = base | 16'h0106;
            4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10:        w = base | 16'h0116;
            4'd11:                                      w = base | 16'h0096;
            4'd12:                                      w = base | 16'h0043;
            default:                                    w = base | 16'h0504;
        endcase
        if (in == 16'h0000) w = 16'h0002;
        return w;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) begin
            m_ctrl[k] = 16'h0000; m_regs[k] = 12'h000; m_valid[k] = 1'b0;
        end
        m_fa = '0; m_fb = '0; m_left = 0;
    endtask

    task automatic model_step(input logic iv, input logic [15:0] in, input logic fl);
        logic        take;
        logic [15:0] w;
        int          fa, fb;
        take = iv && (m_left == 0) && !fl;
        fa = 0; fb = 0;
        // nearest producer first; first hit sticks
        for (int k = 0; k < DEPTH - 1; k++) begin
            if (m_valid[k] && m_ctrl[k][8]) begin
                if (fa == 0 && m_regs[k][11:8] == in[7:4]) fa = k + 1;
                if (fb == 0 && m_regs[k][11:8] == in[3:0]) fb = k + 1;
            end
        end
        w = ref_decode(in);
        if (fa != 0) w = (w & ~16'h0004) | 16'h0200;
        if (fb != 0) w = w | 16'h0018;
        for (int k = DEPTH - 1; k > 0; k--) begin
            m_ctrl[k] = m_ctrl[k-1]; m_regs[k] = m_regs[k-1]; m_valid[k] = m_valid[k-1];
        end
        if (fl) begin
            m_ctrl[1] = 16'h0002; m_regs[1] = 12'h000; m_valid[1] = 1'b0;
        end
        if (take) begin
            m_ctrl[0] = w; m_regs[0] = in[11:0]; m_valid[0] = 1'b1;
            m_fa = SEL_W'(fa); m_fb = SEL_W'(fb);
        end else begin
            m_ctrl[0] = 16'h0002; m_regs[0] = 12'h000; m_valid[0] = 1'b0;
            m_fa = '0; m_fb = '0;
        end
        if (fl)                                 m_left = 0;
        else if (take && in[15:12] == 4'hF)     m_left = MUL_LAT - 1;
        else if (m_left > 0)                    m_left = m_left - 1;
    endtask

    // Drive one cycle of inputs, advance the model, sample 1 ns after the edge
    task automatic tick(input logic iv, input logic [15:0] in, input logic fl);
        inst_valid = iv; inst = in; flush = fl;
        if (!rst_n) model_reset();
        else        model_step(iv, in, fl);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(1'b0, 16'h0000, 1'b0);
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] s_ctrl(input int k);
        return ctrl_stage[16*k +: 16];
    endfunction

    function automatic logic [11:0] s_regs(input int k);
        return regs_stage[12*k +: 12];
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        total++; if (ctrl_stage !== '0) begin bad++; $display("FAIL reset_ctrl: got %h want 0", ctrl_stage); end
        total++; if (regs_stage !== '0) begin bad++; $display("FAIL reset_regs: got %h want 0", regs_stage); end
        total++; if (valid_stage !== '0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_stage); end
        total++; if (fwd_sel_a !== '0 || fwd_sel_b !== '0) begin bad++; $display("FAIL reset_fwd: got %0d/%0d want 0/0", fwd_sel_a, fwd_sel_b); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall); end
    endtask

    task automatic test_issue();
        do_reset();
        tick(1'b1, 16'h0312, 1'b0);
        total++; if (s_ctrl(0) !== 16'h0106) begin bad++; $display("FAIL issue_ctrl: got %h want 0106", s_ctrl(0)); end
        total++; if (s_regs(0) !== 12'h312) begin bad++; $display("FAIL issue_regs: got %h want 312", s_regs(0)); end
        total++; if (valid_stage !== 3'b001) begin bad++; $display("FAIL issue_valid: got %b want 001", valid_stage); end
        total++; if (fwd_sel_a !== '0 || fwd_sel_b !== '0) begin bad++; $display("FAIL issue_fwd: got %0d/%0d want 0/0", fwd_sel_a, fwd_sel_b); end
        tick(1'b0, 16'h0000, 1'b0);
        total++; if (s_ctrl(1) !== 16'h0106 || s_ctrl(0) !== 16'h0002) begin bad++; $display("FAIL shift1: got s1=%h s0=%h want 0106/0002", s_ctrl(1), s_ctrl(0)); end
        tick(1'b0, 16'h0000, 1'b0);
        total++; if (s_ctrl(2) !== 16'h0106 || valid_stage !== 3'b100) begin bad++; $display("FAIL shift2: got s2=%h v=%b want 0106/100", s_ctrl(2), valid_stage); end
        total++; if (s_regs(2) !== 12'h312) begin bad++; $display("FAIL shift2_regs: got %h want 312", s_regs(2)); end
    endtask

    task automatic test_forward();
        // nearest-stage producer on rs
        do_reset();
        tick(1'b1, 16'h0312, 1'b0);
        tick(1'b1, 16'h1435, 1'b0);
        total++; if (s_ctrl(0) !== 16'h0B02) begin bad++; $display("FAIL fwd_near_ctrl: got %h want 0B02", s_ctrl(0)); end
        total++; if (fwd_sel_a !== 3'd1 || fwd_sel_b !== 3'd0) begin bad++; $display("FAIL fwd_near_sel: got %0d/%0d want 1/0", fwd_sel_a, fwd_sel_b); end
        // producer one stage further back
        do_reset();
        tick(1'b1, 16'h0312, 1'b0);
        tick(1'b1, 16'h0400, 1'b0);
        tick(1'b1, 16'h1535, 1'b0);
        total++; if (fwd_sel_a !== 3'd2 || s_ctrl(0) !== 16'h0B02) begin bad++; $display("FAIL fwd_far: got sel=%0d ctrl=%h want 2/0B02", fwd_sel_a, s_ctrl(0)); end
        // two producers of r3: nearest wins
        do_reset();
        tick(1'b1, 16'h0312, 1'b0);
        tick(1'b1, 16'h0300, 1'b0);
        tick(1'b1, 16'h1535, 1'b0);
        total++; if (fwd_sel_a !== 3'd1) begin bad++; $display("FAIL fwd_nearest: got %0d want 1", fwd_sel_a); end
        // rt forwarding on an immediate-class op
        do_reset();
        tick(1'b1, 16'h0312, 1'b0);
        tick(1'b1, 16'h2053, 1'b0);
        total++; if (s_ctrl(0) !== 16'h111E || fwd_sel_a !== 3'd0 || fwd_sel_b !== 3'd1) begin bad++; $display("FAIL fwd_rt: got ctrl=%h sel=%0d/%0d want 111E 0/1", s_ctrl(0), fwd_sel_a, fwd_sel_b); end
        // producer in the last stage is out of reach
        do_reset();
        tick(1'b1, 16'h0312, 1'b0);
        tick(1'b0, 16'h0000, 1'b0);
        tick(1'b0, 16'h0000, 1'b0);
        tick(1'b1, 16'h1435, 1'b0);
        total++; if (fwd_sel_a !== 3'd0 || s_ctrl(0) !== 16'h0906) begin bad++; $display("FAIL fwd_out_of_range: got sel=%0d ctrl=%h want 0/0906", fwd_sel_a, s_ctrl(0)); end
        // a jump does not write a register, so it never forwards
        do_reset();
        tick(1'b1, 16'hB300, 1'b0);
        tick(1'b1, 16'h1435, 1'b0);
        total++; if (fwd_sel_a !== 3'd0) begin bad++; $display("FAIL fwd_nonwriter: got %0d want 0", fwd_sel_a); end
    endtask

    task automatic test_mul_stall();
        do_reset();
        tick(1'b1, 16'hF312, 1'b0);
        total++; if (s_ctrl(0) !== 16'h7D04 || stall !== 1'b1) begin bad++; $display("FAIL mul_issue: got ctrl=%h stall=%b want 7D04/1", s_ctrl(0), stall); end
        tick(1'b1, 16'h0312, 1'b0);
        total++; if (stall !== 1'b1 || valid_stage[0] !== 1'b0 || s_ctrl(0) !== 16'h0002) begin bad++; $display("FAIL mul_stall2: got stall=%b v0=%b ctrl=%h want 1/0/0002", stall, valid_stage[0], s_ctrl(0)); end
        tick(1'b1, 16'h0312, 1'b0);
        total++; if (stall !== 1'b0 || valid_stage[0] !== 1'b0) begin bad++; $display("FAIL mul_stall_end: got stall=%b v0=%b want 0/0", stall, valid_stage[0]); end
        tick(1'b1, 16'h0312, 1'b0);
        total++; if (valid_stage[0] !== 1'b1 || s_ctrl(0) !== 16'h0106) begin bad++; $display("FAIL mul_resume: got v0=%b ctrl=%h want 1/0106", valid_stage[0], s_ctrl(0)); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        tick(1'b1, 16'hF312, 1'b0);
        tick(1'b1, 16'hF445, 1'b0);
        tick(1'b1, 16'hF445, 1'b0);
        total++; if (valid_stage[0] !== 1'b0) begin bad++; $display("FAIL b2b_held: got v0=%b want 0", valid_stage[0]); end
        tick(1'b1, 16'hF445, 1'b0);
        total++; if (valid_stage[0] !== 1'b1 || s_ctrl(0) !== 16'h7D04 || stall !== 1'b1) begin bad++; $display("FAIL b2b_accept: got v0=%b ctrl=%h stall=%b want 1/7D04/1", valid_stage[0], s_ctrl(0), stall); end
    endtask

    task automatic test_flush();
        do_reset();
        tick(1'b1, 16'h0312, 1'b0);
        tick(1'b1, 16'hB005, 1'b0);
        total++; if (s_ctrl(0) !== 16'h5896) begin bad++; $display("FAIL jmp_ctrl: got %h want 5896", s_ctrl(0)); end
        tick(1'b1, 16'h1435, 1'b1);
        total++; if (valid_stage !== 3'b100) begin bad++; $display("FAIL flush_valid: got %b want 100", valid_stage); end
        total++; if (s_ctrl(0) !== 16'h0002 || s_ctrl(1) !== 16'h0002 || s_ctrl(2) !== 16'h0106) begin bad++; $display("FAIL flush_ctrl: got %h/%h/%h want 0002/0002/0106", s_ctrl(0), s_ctrl(1), s_ctrl(2)); end
        tick(1'b1, 16'h0312, 1'b0);
        total++; if (valid_stage[0] !== 1'b1 || s_ctrl(0) !== 16'h0106) begin bad++; $display("FAIL flush_represent: got v0=%b ctrl=%h want 1/0106", valid_stage[0], s_ctrl(0)); end
        // flush during a multiply stall releases issue next cycle
        do_reset();
        tick(1'b1, 16'hF312, 1'b0);
        tick(1'b0, 16'h0000, 1'b1);
        total++; if (stall !== 1'b0 || valid_stage !== 3'b000) begin bad++; $display("FAIL flush_stall: got stall=%b v=%b want 0/000", stall, valid_stage); end
        tick(1'b1, 16'h0312, 1'b0);
        total++; if (valid_stage[0] !== 1'b1) begin bad++; $display("FAIL flush_stall_issue: got v0=%b want 1", valid_stage[0]); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        tick(1'b1, 16'hF312, 1'b0);
        tick(1'b0, 16'h0000, 1'b0);
        rst_n = 1'b0;
        tick(1'b1, 16'h0312, 1'b0);
        rst_n = 1'b1;
        total++; if (stall !== 1'b0 || ctrl_stage !== '0 || regs_stage !== '0 || valid_stage !== '0) begin bad++; $display("FAIL reset_mid_stall: got stall=%b ctrl=%h v=%b want all 0", stall, ctrl_stage, valid_stage); end
        tick(1'b1, 16'h0312, 1'b0);
        total++; if (valid_stage[0] !== 1'b1) begin bad++; $display("FAIL reset_mid_stall_issue: got v0=%b want 1", valid_stage[0]); end
    endtask

    task automatic test_random();
        logic [16*DEPTH-1:0] e_ctrl;
        logic [12*DEPTH-1:0] e_regs;
        logic [DEPTH-1:0]    e_valid;
        logic [15:0]         r_inst;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            r_inst = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
                      4'($urandom_range(0, 3)),  4'($urandom_range(0, 3))};
            rst_n = ($urandom_range(0, 99) != 0);
            tick($urandom_range(0, 3) != 0, r_inst, $urandom_range(0, 9) == 0);
            rst_n = 1'b1;
            for (int k = 0; k < DEPTH; k++) begin
                e_ctrl[16*k +: 16] = m_ctrl[k];
                e_regs[12*k +: 12] = m_regs[k];
                e_valid[k]         = m_valid[k];
            end
            total++; if (ctrl_stage !== e_ctrl) begin bad++; $display("FAIL rnd_ctrl[%0d]: got %h want %h", n, ctrl_stage, e_ctrl); end
            total++; if (regs_stage !== e_regs) begin bad++; $display("FAIL rnd_regs[%0d]: got %h want %h", n, regs_stage, e_regs); end
            total++; if (valid_stage !== e_valid) begin bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, valid_stage, e_valid); end
            total++; if (fwd_sel_a !== m_fa || fwd_sel_b !== m_fb) begin bad++; $display("FAIL rnd_fwd[%0d]: got %0d/%0d want %0d/%0d", n, fwd_sel_a, fwd_sel_b, m_fa, m_fb); end
            total++; if (stall !== (m_left != 0)) begin bad++; $display("FAIL rnd_stall[%0d]: got %b want %b", n, stall, (m_left != 0)); end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        inst_valid = 1'b0;
        inst       = 16'h0000;
        flush      = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_issue();
        test_forward();
        test_mul_stall();
        test_back_to_back();
        test_flush();
        test_reset_mid_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
